m8088_bus_target: RTL and testbench
===================================

// Module: m8088_bus_target
// PURPOSE
//  Minimum-mode 8088 bus responder: the target end of the CPU's ALE/RD_n/WR_n/IOM/INTA_n cycle.
//  Latches the multiplexed address on ALE, runs a req/ack transaction to a backing store, and holds READY low until done.
//  Returns read data on the CPU din bus. Sits between the CPU core and the system memory/IO fabric.
// PARAMETERS
//  MIN_WAIT   1    minimum wait states (CORE_CLK cycles READY held low after strobe), 0..15
//  TIMEOUT    255  CORE_CLK cycles allowed for bs_ack before forced completion, 1..255
//  INT_VECTOR 8'h08 reset value of vector register (only with M8088_TARGET_INTA_EN)
// PORTS
//  CORE_CLK    in   1   single clock; all CPU-side signals are synchronous to it
//  RESET_n     in   1   asynchronous, active-low reset
//  ALE         in   1   address latch enable from CPU
//  addr        in   20  CPU address (valid while ALE high)
//  cpu_dout    in   8   CPU write data
//  RD_n/WR_n   in   1   read/write strobes, active low
//  IOM         in   1   1=memory, 0=IO cycle
//  INTA_n      in   1   interrupt acknowledge strobe, active low
//  cpu_din     out  8   read data / interrupt vector to CPU
//  READY       out  1   CPU ready; low inserts wait states
//  bs_req      out  1   backing-store request, held until bs_ack
//  bs_we       out  1   1=write
//  bs_io       out  1   1=IO space (bs_addr[19:16] forced 0)
//  bs_addr     out  20  latched address
//  bs_wdata    out  8   write data
//  bs_ack      in   1   one-cycle completion pulse
//  bs_rdata    in   8   read data, valid with bs_ack
//  timeout_err out  1   sticky; set on any timeout, cleared by reset only
//  vec_we      in   1   load int vector from vec_data (macro only)
//  vec_data    in   8   vector value (macro only)
// BEHAVIOUR
//  Reset: state IDLE, READY=1, cpu_din=8'hFF, bs_req=0, bs_we=0, bs_io=0, bs_addr=0, bs_wdata=0, timeout_err=0.
//  FSM IDLE->ADDR->REQ->WAIT->DONE->IDLE.
//  IDLE: ALE=1 latches addr/IOM each cycle; ALE falling -> ADDR.
//  ADDR: first of RD_n=0 or WR_n=0 -> REQ, READY<=0 next edge.
//   RD_n&WR_n both low: treat as read. ALE rising again in ADDR: relatch, stay in ADDR.
//  REQ: bs_req=1; bs_we/bs_io/bs_wdata driven. cpu_dout sampled in REQ entry cycle.
//   Start wait counter (MIN_WAIT) and timeout counter (TIMEOUT) -> WAIT.
//  WAIT: bs_req held until bs_ack (also checked in REQ cycle); read: cpu_din<=bs_rdata on ack.
//   Go DONE when ack seen AND wait counter expired; READY<=1 same edge.
//   MIN_WAIT=0 and ack in REQ cycle: READY low exactly one cycle.
//   Timeout: counter hits 0 without ack -> bs_req=0, cpu_din=8'hFF (reads), timeout_err=1, -> DONE.
//   Ack arriving after timeout ignored.
//  DONE: READY=1, cpu_din held until both strobes high -> IDLE. Strobe released early (reset of CPU) same.
//  Data latency read: strobe edge -> READY high = max(MIN_WAIT, ack delay)+1 cycles.
//  Only one outstanding bs transaction; bs_req never reasserted before DONE->IDLE.
//  Mid-operation RESET_n low: immediate return to reset values, bs_req drops asynchronously.
// CONFIGURATION
//  M8088_TARGET_INTA_EN defined: INTA_n cycles handled in ADDR.
//   8088 issues two INTA pulses: first pulse -> READY stays 1, no bs transaction.
//   Second pulse -> cpu_din = vector register, READY stays 1.
//   Pulse counter reset on every ALE and on reset. vec_we loads vector register (reset value INT_VECTOR).
//  Undefined: INTA_n ignored, cpu_din stays 8'hFF, vec_we/vec_data unused, no vector register.
// STRUCTURE
//  Shared package m8088_pkg: state enum (IDLE/ADDR/REQ/WAIT/DONE), BUS_IDLE_DATA=8'hFF, ADDR_W=20.
//  Sub-module m8088_target_cnt: loadable down-counter with zero flag.
//   Instantiated twice (wait states, timeout). FSM and datapath flat in top.
// TESTING
//  Mem read A=20'h12345, MIN_WAIT=1, ack 3 cycles after req, rdata=8'hA5
//   -> bs_addr=12345, bs_io=0, READY low 4 cycles, cpu_din=A5.
//  IO write port 16'h0040, data 8'h3C, ack in REQ cycle, MIN_WAIT=2
//   -> bs_io=1, bs_addr=20'h00040, bs_we=1, bs_wdata=3C, READY low 3 cycles.
//  Read, no ack, TIMEOUT=4 -> READY high after 5 cycles, cpu_din=FF, timeout_err=1; late ack ignored.
//  RESET_n low during WAIT -> bs_req=0 and READY=1 asynchronously; next cycle completes normally.
//  INTA_EN: vec_we with 8'h21, two INTA pulses -> READY never low, no bs_req, cpu_din=21 on second pulse.
//  Back-to-back reads, strobe held 2 cycles after READY -> data held, exactly one bs_req per cycle.

Source files
------------

// File: rtl/m8088_pkg.sv
// Shared types and constants for the minimum-mode 8088 bus target.
package m8088_pkg;

    localparam int         ADDR_W        = 20;
    localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        REQ,
        WAIT,
        DONE
    } state_e;

    // IO cycles only decode a 16-bit port number, so the top nibble is cleared.
    function automatic logic [ADDR_W-1:0] bus_addr(input logic [ADDR_W-1:0] a,
                                                   input logic              is_mem);
        return is_mem ? a : {4'h0, a[15:0]};
    endfunction

endpackage

// File: rtl/m8088_target_cnt.sv
// Loadable down-counter that stops at zero and flags when it is there.
module m8088_target_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/m8088_bus_target.sv
// Minimum-mode 8088 bus responder: latches the address on ALE, runs one req/ack backing-store
// transaction per strobe and inserts wait states via READY. Define M8088_TARGET_INTA_EN for INTA cycles.
module m8088_bus_target
    import m8088_pkg::*;
#(
    parameter int         MIN_WAIT   = 1,
    parameter int         TIMEOUT    = 255,
    parameter logic [7:0] INT_VECTOR = 8'h08
) (
    input  logic              CORE_CLK,
    input  logic              RESET_n,
    input  logic              ALE,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        cpu_dout,
    input  logic              RD_n,
    input  logic              WR_n,
    input  logic              IOM,
    input  logic              INTA_n,
    output logic [7:0]        cpu_din,
    output logic              READY,
    output logic              bs_req,
    output logic              bs_we,
    output logic              bs_io,
    output logic [ADDR_W-1:0] bs_addr,
    output logic [7:0]        bs_wdata,
    input  logic              bs_ack,
    input  logic [7:0]        bs_rdata,
    output logic              timeout_err,
    input  logic              vec_we,
    input  logic [7:0]        vec_data
);

    localparam logic [3:0] WAIT_LOAD = 4'(MIN_WAIT);
    localparam logic [7:0] TO_LOAD   = 8'(TIMEOUT);

    state_e              state_q, state_d;
    logic                ale_q, ale_d;
    logic                iom_q, iom_d;
    logic [ADDR_W-1:0]   bs_addr_q, bs_addr_d;
    logic                bs_req_q, bs_req_d;
    logic                bs_we_q, bs_we_d;
    logic                bs_io_q, bs_io_d;
    logic [7:0]          bs_wdata_q, bs_wdata_d;
    logic [7:0]          cpu_din_q, cpu_din_d;
    logic                ready_q, ready_d;
    logic                timeout_err_q, timeout_err_d;
    logic                ack_seen_q, ack_seen_d;

    logic                start_req;
    logic                counting;
    logic                ack_now;
    logic                got_ack;
    logic                wait_zero;
    logic                to_zero;

`ifdef M8088_TARGET_INTA_EN
    logic                inta_q, inta_d;
    logic                pulse_q, pulse_d;
    logic [7:0]          vec_q, vec_d;
`else
    logic                unused_inta;
    assign unused_inta = ^{INTA_n, vec_we, vec_data, INT_VECTOR};
`endif

    assign counting = (state_q == REQ) || (state_q == WAIT);

    m8088_target_cnt #(.W(4)) u_wait_cnt (
        .clk      (CORE_CLK),
        .rst_n    (RESET_n),
        .load     (start_req),
        .en       (counting),
        .load_val (WAIT_LOAD),
        .zero     (wait_zero)
    );

    m8088_target_cnt #(.W(8)) u_timeout_cnt (
        .clk      (CORE_CLK),
        .rst_n    (RESET_n),
        .load     (start_req),
        .en       (counting),
        .load_val (TO_LOAD),
        .zero     (to_zero)
    );

    always_comb begin
        state_d       = state_q;
        ale_d         = ALE;
        iom_d         = iom_q;
        bs_addr_d     = bs_addr_q;
        bs_req_d      = bs_req_q;
        bs_we_d       = bs_we_q;
        bs_io_d       = bs_io_q;
        bs_wdata_d    = bs_wdata_q;
        cpu_din_d     = cpu_din_q;
        ready_d       = ready_q;
        timeout_err_d = timeout_err_q;
        ack_seen_d    = ack_seen_q;
        start_req     = 1'b0;
        ack_now       = 1'b0;
        got_ack       = 1'b0;
`ifdef M8088_TARGET_INTA_EN
        inta_d        = INTA_n;
        pulse_d       = ALE ? 1'b0 : pulse_q;
        vec_d         = vec_we ? vec_data : vec_q;
`endif

        case (state_q)
            IDLE: begin
                if (ALE) begin
                    iom_d     = IOM;
                    bs_addr_d = bus_addr(addr, IOM);
                end else if (ale_q) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ALE) begin
                    iom_d     = IOM;
                    bs_addr_d = bus_addr(addr, IOM);
                end else if (!RD_n || !WR_n) begin
                    // Both strobes low is resolved as a read.
                    state_d    = REQ;
                    ready_d    = 1'b0;
                    bs_req_d   = 1'b1;
                    bs_we_d    = RD_n;
                    bs_io_d    = ~iom_q;
                    bs_wdata_d = cpu_dout;
                    ack_seen_d = 1'b0;
                    start_req  = 1'b1;
                end
`ifdef M8088_TARGET_INTA_EN
                else if (!INTA_n && inta_q) begin
                    if (pulse_q) begin
                        cpu_din_d = vec_q;
                    end else begin
                        pulse_d = 1'b1;
                    end
                end
`endif
            end
            REQ, WAIT: begin
                ack_now = bs_ack && bs_req_q;
                got_ack = ack_now || ack_seen_q;
                if (ack_now) begin
                    bs_req_d   = 1'b0;
                    ack_seen_d = 1'b1;
                    if (!bs_we_q) begin
                        cpu_din_d = bs_rdata;
                    end
                end
                if (got_ack && wait_zero) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else if (!got_ack && to_zero) begin
                    bs_req_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    ready_d       = 1'b1;
                    state_d       = DONE;
                    if (!bs_we_q) begin
                        cpu_din_d = BUS_IDLE_DATA;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (RD_n && WR_n) begin
                    state_d   = IDLE;
                    cpu_din_d = BUS_IDLE_DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CORE_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q       <= IDLE;
            ale_q         <= 1'b0;
            iom_q         <= 1'b0;
            bs_addr_q     <= '0;
            bs_req_q      <= 1'b0;
            bs_we_q       <= 1'b0;
            bs_io_q       <= 1'b0;
            bs_wdata_q    <= '0;
            cpu_din_q     <= BUS_IDLE_DATA;
            ready_q       <= 1'b1;
            timeout_err_q <= 1'b0;
            ack_seen_q    <= 1'b0;
`ifdef M8088_TARGET_INTA_EN
            inta_q        <= 1'b1;
            pulse_q       <= 1'b0;
            vec_q         <= INT_VECTOR;
`endif
        end else begin
            state_q       <= state_d;
            ale_q         <= ale_d;
            iom_q         <= iom_d;
            bs_addr_q     <= bs_addr_d;
            bs_req_q      <= bs_req_d;
            bs_we_q       <= bs_we_d;
            bs_io_q       <= bs_io_d;
            bs_wdata_q    <= bs_wdata_d;
            cpu_din_q     <= cpu_din_d;
            ready_q       <= ready_d;
            timeout_err_q <= timeout_err_d;
            ack_seen_q    <= ack_seen_d;
`ifdef M8088_TARGET_INTA_EN
            inta_q        <= inta_d;
            pulse_q       <= pulse_d;
            vec_q         <= vec_d;
`endif
        end
    end

    assign cpu_din     = cpu_din_q;
    assign READY       = ready_q;
    assign bs_req      = bs_req_q;
    assign bs_we       = bs_we_q;
    assign bs_io       = bs_io_q;
    assign bs_addr     = bs_addr_q;
    assign bs_wdata    = bs_wdata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_m8088_bus_target.sv
// Directed bench for m8088_bus_target: u_dut1 (MIN_WAIT=1, TIMEOUT=4) and u_dut2 (MIN_WAIT=2),
// sharing the CPU address bus, each with its own strobes and backing-store ack.
module tb_m8088_bus_target;

    logic        CORE_CLK = 1'b0;
    logic        RESET_n;
    logic        ale;
    logic [19:0] addr;
    logic [7:0]  cpu_dout;
    logic        iom;
    logic        inta_n;
    logic        rd1_n, wr1_n, rd2_n, wr2_n;
    logic        ack1, ack2;
    logic [7:0]  rdata;
    logic        vec_we;
    logic [7:0]  vec_data;

    logic [7:0]  cpu_din1, cpu_din2;
    logic        ready1, ready2;
    logic        bs_req1, bs_req2;
    logic        bs_we1, bs_we2;
    logic        bs_io1, bs_io2;
    logic [19:0] bs_addr1, bs_addr2;
    logic [7:0]  bs_wdata1, bs_wdata2;
    logic        terr1, terr2;

    int checks = 0;
    int passed = 0;
    int failed = 0;
    int req_rise1 = 0;
    int low;
    int req_base;

    always #5 CORE_CLK = ~CORE_CLK;

    always @(posedge bs_req1) req_rise1++;

    m8088_bus_target #(.MIN_WAIT(1), .TIMEOUT(4), .INT_VECTOR(8'h08)) u_dut1 (
        .CORE_CLK(CORE_CLK), .RESET_n(RESET_n), .ALE(ale), .addr(addr), .cpu_dout(cpu_dout),
        .RD_n(rd1_n), .WR_n(wr1_n), .IOM(iom), .INTA_n(inta_n), .cpu_din(cpu_din1),
        .READY(ready1), .bs_req(bs_req1), .bs_we(bs_we1), .bs_io(bs_io1), .bs_addr(bs_addr1),
        .bs_wdata(bs_wdata1), .bs_ack(ack1), .bs_rdata(rdata), .timeout_err(terr1),
        .vec_we(vec_we), .vec_data(vec_data)
    );

    m8088_bus_target #(.MIN_WAIT(2), .TIMEOUT(255), .INT_VECTOR(8'h08)) u_dut2 (
        .CORE_CLK(CORE_CLK), .RESET_n(RESET_n), .ALE(ale), .addr(addr), .cpu_dout(cpu_dout),
        .RD_n(rd2_n), .WR_n(wr2_n), .IOM(iom), .INTA_n(inta_n), .cpu_din(cpu_din2),
        .READY(ready2), .bs_req(bs_req2), .bs_we(bs_we2), .bs_io(bs_io2), .bs_addr(bs_addr2),
        .bs_wdata(bs_wdata2), .bs_ack(ack2), .bs_rdata(rdata), .timeout_err(terr2),
        .vec_we(vec_we), .vec_data(vec_data)
    );

    task automatic tick;
        @(posedge CORE_CLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Address phase: one ALE-high cycle, then ALE low so the target sits in ADDR.
    task automatic apply_stimulus(input logic [19:0] a, input logic mem);
        ale  = 1'b1;
        addr = a;
        iom  = mem;
        tick;
        ale  = 1'b0;
        addr = 20'hFFFFF;
        tick;
    endtask

    // Call right after driving a strobe low. ack is sampled by the DUT on the edge after
    // loop index ack_cycle; low_cnt is the number of cycles READY was seen low.
    task automatic bus_wait(input int sel, input int ack_cycle, output int low_cnt);
        low_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (sel == 1) ack1 = (c == ack_cycle);
            else          ack2 = (c == ack_cycle);
            if (c == 0) check_output("bs_req_asserted", (sel == 1) ? bs_req1 : bs_req2, 1);
            if (((sel == 1) ? ready1 : ready2) == 1'b1) break;
            low_cnt++;
        end
        ack1 = 1'b0;
        ack2 = 1'b0;
    endtask

    initial begin
        RESET_n  = 1'b1;
        ale      = 1'b0;
        addr     = '0;
        cpu_dout = '0;
        iom      = 1'b1;
        inta_n   = 1'b1;
        rd1_n    = 1'b1; wr1_n = 1'b1;
        rd2_n    = 1'b1; wr2_n = 1'b1;
        ack1     = 1'b0; ack2  = 1'b0;
        rdata    = '0;
        vec_we   = 1'b0;
        vec_data = '0;

        // Reset values, checked asynchronously before any clock edge
        #2 RESET_n = 1'b0;
        #1;
        check_output("rst_ready",    ready1,    1);
        check_output("rst_cpu_din",  cpu_din1,  8'hFF);
        check_output("rst_bs_req",   bs_req1,   0);
        check_output("rst_bs_we",    bs_we1,    0);
        check_output("rst_bs_io",    bs_io1,    0);
        check_output("rst_bs_addr",  bs_addr1,  0);
        check_output("rst_bs_wdata", bs_wdata1, 0);
        check_output("rst_terr",     terr1,     0);
        check_output("rst_ready2",   ready2,    1);
        tick;
        tick;
        RESET_n = 1'b1;
        tick;

        // Memory read 12345, ack 3 cycles after the REQ cycle
        $display("[TB] memory read with delayed ack");
        apply_stimulus(20'h12345, 1'b1);
        rdata = 8'hA5;
        rd1_n = 1'b0;
        bus_wait(1, 3, low);
        check_output("rd_ready_low", low,       4);
        check_output("rd_cpu_din",   cpu_din1,  8'hA5);
        check_output("rd_bs_addr",   bs_addr1,  20'h12345);
        check_output("rd_bs_io",     bs_io1,    0);
        check_output("rd_bs_we",     bs_we1,    0);
        check_output("rd_bs_req_off", bs_req1,  0);
        tick;
        tick;
        check_output("rd_hold_din",   cpu_din1, 8'hA5);
        check_output("rd_hold_ready", ready1,   1);
        rd1_n = 1'b1;
        tick;
        tick;
        check_output("rd_idle_din", cpu_din1, 8'hFF);

        // IO write on u_dut2; upper address bits on the bus must be cleared
        $display("[TB] IO write with ack in REQ cycle");
        apply_stimulus(20'h50040, 1'b0);
        cpu_dout = 8'h3C;
        wr2_n    = 1'b0;
        bus_wait(2, 0, low);
        check_output("wr_ready_low", low,       3);
        check_output("wr_bs_io",     bs_io2,    1);
        check_output("wr_bs_addr",   bs_addr2,  20'h00040);
        check_output("wr_bs_we",     bs_we2,    1);
        check_output("wr_bs_wdata",  bs_wdata2, 8'h3C);
        check_output("wr_bs_req_off", bs_req2,  0);
        check_output("wr_terr",      terr2,     0);
        wr2_n = 1'b1;
        tick;
        tick;

        // Read with no ack on u_dut1 (TIMEOUT=4)
        $display("[TB] read timeout");
        apply_stimulus(20'h00100, 1'b1);
        rdata = 8'h5A;
        rd1_n = 1'b0;
        bus_wait(1, -1, low);
        check_output("to_ready_low", low,      5);
        check_output("to_cpu_din",   cpu_din1, 8'hFF);
        check_output("to_terr",      terr1,    1);
        check_output("to_bs_req",    bs_req1,  0);
        ack1 = 1'b1;
        tick;
        ack1 = 1'b0;
        tick;
        check_output("to_late_ack_din", cpu_din1, 8'hFF);
        check_output("to_late_ready",   ready1,   1);
        rd1_n = 1'b1;
        tick;
        tick;
        check_output("to_terr_sticky", terr1, 1);

        // Asynchronous reset in the middle of WAIT
        $display("[TB] reset during WAIT");
        apply_stimulus(20'h0ABCD, 1'b1);
        rd1_n = 1'b0;
        tick;
        tick;
        check_output("mid_ready_low", ready1,  0);
        check_output("mid_bs_req",    bs_req1, 1);
        #1 RESET_n = 1'b0;
        #1;
        check_output("mid_rst_bs_req", bs_req1,  0);
        check_output("mid_rst_ready",  ready1,   1);
        check_output("mid_rst_terr",   terr1,    0);
        check_output("mid_rst_din",    cpu_din1, 8'hFF);
        tick;
        rd1_n = 1'b1;
        tick;
        RESET_n = 1'b1;
        tick;
        apply_stimulus(20'h0ABCD, 1'b1);
        rdata = 8'hC3;
        rd1_n = 1'b0;
        bus_wait(1, 0, low);
        check_output("post_rst_low",  low,      2);
        check_output("post_rst_din",  cpu_din1, 8'hC3);
        check_output("post_rst_addr", bs_addr1, 20'h0ABCD);
        rd1_n = 1'b1;
        tick;
        tick;

        // Interrupt acknowledge: two INTA pulses within one address phase
        $display("[TB] INTA sequence");
        vec_we   = 1'b1;
        vec_data = 8'h21;
        tick;
        vec_we   = 1'b0;
        req_base = req_rise1;
        apply_stimulus(20'h00000, 1'b0);
        inta_n = 1'b0;
        tick;
        inta_n = 1'b1;
        tick;
        check_output("inta1_ready",  ready1,   1);
        check_output("inta1_bs_req", bs_req1,  0);
        check_output("inta1_din",    cpu_din1, 8'hFF);
        inta_n = 1'b0;
        tick;
        check_output("inta2_ready",  ready1,   1);
        check_output("inta2_bs_req", bs_req1,  0);
`ifdef M8088_TARGET_INTA_EN
        check_output("inta2_din",    cpu_din1, 8'h21);
`else
        check_output("inta2_din",    cpu_din1, 8'hFF);
`endif
        inta_n = 1'b1;
        tick;
        check_output("inta_no_req", req_rise1 - req_base, 0);

        // Back-to-back reads, strobe held two cycles after READY
        $display("[TB] back-to-back reads");
        req_base = req_rise1;
        apply_stimulus(20'h20000, 1'b1);
        rdata = 8'h11;
        rd1_n = 1'b0;
        bus_wait(1, 1, low);
        check_output("b2b1_low", low, 2);
        tick;
        tick;
        check_output("b2b1_hold_din", cpu_din1, 8'h11);
        check_output("b2b1_hold_req", bs_req1,  0);
        rd1_n = 1'b1;
        tick;
        apply_stimulus(20'h20001, 1'b1);
        rdata = 8'h22;
        rd1_n = 1'b0;
        bus_wait(1, 2, low);
        check_output("b2b2_low",  low,      3);
        check_output("b2b2_din",  cpu_din1, 8'h22);
        check_output("b2b2_addr", bs_addr1, 20'h20001);
        tick;
        tick;
        check_output("b2b2_hold_din", cpu_din1, 8'h22);
        check_output("b2b2_hold_req", bs_req1,  0);
        rd1_n = 1'b1;
        tick;
        tick;
        check_output("b2b_req_count", req_rise1 - req_base, 2);
        check_output("b2b_terr",      terr1,                0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
